// File: rtl/link_rx_buffer.sv
// link_rx_buffer: responder end of the 4-phase req/ack byte link.
// Each accepted transfer is written into a small FIFO and presented on a
// first-word fall-through valid/ready read port. While the FIFO is full the
// responder withholds ack, which stalls the link master.
module link_rx_buffer #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int ACK_HOLD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req,
  input  logic [DATA_W-1:0]          data,
  output logic                       ack,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 rx_total
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(ACK_HOLD + 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_INI = HW'(ACK_HOLD - 1);

  typedef enum logic [0:0] {IDLE, ACK_HI} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HW-1:0]     hold_cnt;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push;
  logic              pop;

  // Full is judged on the registered count only, so a same-edge pop never
  // lets a stalled request in; it is taken at the following edge instead.
  assign push      = (state == IDLE) && req && (count != FULL);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rptr];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, release once the hold expires and req is low.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push) state_nxt = ACK_HI;
      ACK_HI:  if ((hold_cnt == '0) && !req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: ack is a pure function of the state register.
  always_comb begin
    ack = (state == ACK_HI);
  end

  // Minimum-ack-width counter, loaded on acceptance and run down in ACK_HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (push) begin
      hold_cnt <= HOLD_INI;
    end else if ((state == ACK_HI) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  // FIFO control: pointers wrap naturally, occupancy tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rx_total <= '0;
    end else begin
      if (push) begin
        wptr     <= wptr + 1'b1;
        rx_total <= rx_total + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // FIFO storage: data path only, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

endmodule

// File: doc/link_rx_buffer.md
Name: link_rx_buffer

Overview:
- Responder end of the 4-phase req/ack byte link driven by the link master. Each accepted transfer is pushed into an internal FIFO and presented downstream on a valid/ready read port.
- Backpressure reaches the master by withholding ack while the FIFO is full.
- Replaces the bare slave in link_top wherever the consumer cannot take a byte every handshake.

Parameters:
- DATA_W, 8, width of link data and FIFO entries
- DEPTH, 4, FIFO entries; power of two, >= 2
- ACK_HOLD, 1, minimum cycles ack stays high per transfer; >= 1

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  1  master request; data valid while high
- data  input  DATA_W  master data, stable while req high
- ack  output  1  handshake acknowledge, registered
- out_data  output  DATA_W  head-of-FIFO entry (first-word fall-through)
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer pop; pop occurs when out_valid && out_ready
- count  output  $clog2(DEPTH)+1  current FIFO occupancy
- rx_total  output  8  accepted-transfer counter, wraps 255->0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset (rst high at a rising edge):
  - ack=0, state=IDLE, count=0, out_valid=0, rx_total=0, read/write pointers=0.
  - out_data is don't-care while out_valid=0.
  - Reset mid-handshake discards FIFO contents and in-flight state. If req is still high after reset, the byte is accepted again as a new transfer. This duplicate is the intended behaviour.
- FSM states: IDLE, ACK_HI.
- IDLE:
  - ack=0.
  - At an edge with req=1 and count<DEPTH (registered count): write data at wptr, wptr+1, rx_total+1, ack<=1, hold_cnt<=ACK_HOLD-1, go to ACK_HI.
  - If req=1 and FIFO full: stay in IDLE, ack stays 0, nothing written. Acceptance occurs at the first edge where count<DEPTH.
- ACK_HI:
  - ack=1.
  - If hold_cnt!=0, decrement hold_cnt.
  - At an edge with hold_cnt==0 and req==0: ack<=0, go to IDLE.
  - req dropping early is allowed. ack still holds for ACK_HOLD cycles, then falls.
  - No write occurs in ACK_HI, so each handshake writes exactly one entry.
- Latency:
  - req high sampled at edge N (IDLE, not full): ack=1, out_valid=1 (if FIFO was empty) and out_data=data, all after edge N.
  - With ACK_HOLD=1: ack falls at the first edge in ACK_HI where req=0.
  - Minimum handshake period is 4 cycles when the master reacts in 1 cycle.
- FIFO:
  - out_valid = (count!=0); out_data = mem[rptr].
  - Pop at edge: rptr+1.
  - Push and pop at the same edge: count unchanged, both pointers advance.
  - Full is evaluated on registered count only. A pop at the same edge as a full-stalled req does not allow the push. The push occurs at the next edge.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Pop with out_valid=0 is ignored.
- Widths: count is one bit wider than the pointers, range 0..DEPTH. Overflow and underflow are impossible by construction. The bench asserts count<=DEPTH.
- ack changes only on clock edges (registered); it never depends combinationally on req.

Test Plan:
- Single transfer, DEPTH=4, ACK_HOLD=1, out_ready=0: req=1 with data=0xA5 at edge N -> ack=1 and out_valid=1 with out_data=0xA5 after N; master drops req -> ack=0 one edge later; count=1, rx_total=1.
- Fill and stall, out_ready=0: five handshakes with data 0x01..0x05 -> first four acked, count=4; fifth req stays high with ack=0 indefinitely. Assert out_ready for one cycle -> 0x01 popped, count=3 at that edge, then 0x05 accepted at the following edge, count=4.
- Streaming, out_ready=1: 16 bytes 0x10..0x1F -> consumer sees exactly 0x10..0x1F in order, no duplicates or drops; count never exceeds 1; rx_total=16; pointers wrap 4 times.
- ACK_HOLD=3 with req dropped 1 cycle after ack rises -> ack high for exactly 3 cycles, then 0.
- Reset mid-handshake: rst pulsed while in ACK_HI with count=2 and req held high -> after reset ack=0, count=0, rx_total=0; next edge re-accepts the byte, ack=1, count=1.
- Simultaneous push/pop at count=2 -> count stays 2; the read sequence is the oldest entry first.
